// File: rtl/ntt_bfu_scheduler.sv
// Issue sequencer for an in-place NTT/INTT on one bank: one butterfly per cycle, with write-back
// addresses delayed to line up with the butterfly outputs. Optional NTT_STALL_EN adds iSTALL.
module ntt_bfu_scheduler #(
  parameter int LOGN    = 10,
  parameter int BFU_LAT = 5,
  parameter int RD_LAT  = 1
) (
  input  logic                     iSYS_CLK,
  input  logic                     iSYS_RST,
`ifdef NTT_STALL_EN
  input  logic                     iSTALL,
`endif
  input  logic                     iSTART,
  input  logic                     iMODE,
  output logic                     oBUSY,
  output logic                     oDONE,
  output logic                     oRD_EN,
  output logic [LOGN-1:0]          oRD_ADDR_A,
  output logic [LOGN-1:0]          oRD_ADDR_B,
  output logic [LOGN:0]            oTW_ADDR,
  output logic                     oBFU_START,
  output logic                     oBFU_SEL,
  output logic                     oWR_EN,
  output logic [LOGN-1:0]          oWR_ADDR_A,
  output logic [LOGN-1:0]          oWR_ADDR_B,
  output logic [$clog2(LOGN)-1:0]  oSTAGE
);

  localparam int SW = $clog2(LOGN);
  localparam int JW = LOGN - 1;
  localparam int D  = RD_LAT + BFU_LAT;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [JW-1:0]   J_LAST     = '1;
  localparam logic [SW-1:0]   LAST_STAGE = SW'(LOGN - 1);
  localparam logic [LOGN-1:0] ONE_A      = LOGN'(1);
  localparam logic [LOGN:0]   ONE_TW     = (LOGN+1)'(1);
  localparam logic [LOGN:0]   TW_N       = ONE_TW << LOGN;

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [JW-1:0]   j_q, j_d;
  logic            mode_q, mode_d;

  logic [D-1:0]    vld_q;
  logic [LOGN-1:0] dla_q [D];
  logic [LOGN-1:0] dlb_q [D];

  logic            stall;
  logic            rd_en;
  logic            older_pending;
  logic [SW-1:0]   len_log;
  logic [LOGN-1:0] j_ext, grp, off, mask, addr_a, addr_b;
  logic [LOGN:0]   tw_addr;

`ifdef NTT_STALL_EN
  assign stall = iSTALL;
`else
  assign stall = 1'b0;
`endif

  assign rd_en = (state_q == ST_ISSUE) && !stall;

  // Forward stages halve the butterfly span each stage; inverse stages double it.
  always_comb begin
    j_ext   = {1'b0, j_q};
    len_log = mode_q ? stage_q : (LAST_STAGE - stage_q);
    grp     = j_ext >> len_log;
    mask    = (ONE_A << len_log) - ONE_A;
    off     = j_ext & mask;
    addr_a  = ((grp << len_log) << 1) | off;
    addr_b  = addr_a | (ONE_A << len_log);
    if (mode_q) begin
      tw_addr = TW_N + ((TW_N >> 1) >> stage_q) + {1'b0, grp};
    end else begin
      tw_addr = (ONE_TW << stage_q) + {1'b0, grp};
    end
  end

  // Entries 0..D-2 empty means the head holds the last write of the stage.
  always_comb begin
    older_pending = 1'b0;
    for (int i = 0; i < D - 1; i++) begin
      older_pending = older_pending | vld_q[i];
    end
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          state_d = ST_ISSUE;
          stage_d = '0;
          j_d     = '0;
          mode_d  = iMODE;
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          j_d = j_q + JW'(1);
          if (j_q == J_LAST) begin
            state_d = ST_DRAIN;
            j_d     = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (vld_q[D-1] && !older_pending) begin
          if (stage_q == LAST_STAGE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge iSYS_CLK) begin
    if (!iSYS_RST) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      j_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      mode_q  <= mode_d;
    end
  end

  always_ff @(posedge iSYS_CLK) begin
    if (!iSYS_RST) begin
      // NOTE: the delay line is cleared on reset (unlike a RAM) because its valid bits
      // drive write strobes; stale entries would corrupt the bank after a mid-run reset.
      vld_q <= '0;
      for (int i = 0; i < D; i++) begin
        dla_q[i] <= '0;
        dlb_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_en;
      dla_q[0] <= rd_en ? addr_a : '0;
      dlb_q[0] <= rd_en ? addr_b : '0;
      for (int i = 1; i < D; i++) begin
        vld_q[i] <= vld_q[i-1];
        dla_q[i] <= dla_q[i-1];
        dlb_q[i] <= dlb_q[i-1];
      end
    end
  end

  assign oBUSY      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign oDONE      = (state_q == ST_DONE);
  assign oRD_EN     = rd_en;
  assign oRD_ADDR_A = rd_en ? addr_a  : '0;
  assign oRD_ADDR_B = rd_en ? addr_b  : '0;
  assign oTW_ADDR   = rd_en ? tw_addr : '0;
  assign oBFU_START = oBUSY;
  assign oBFU_SEL   = mode_q;
  assign oWR_EN     = vld_q[D-1];
  assign oWR_ADDR_A = dla_q[D-1];
  assign oWR_ADDR_B = dlb_q[D-1];
  assign oSTAGE     = stage_q;

endmodule

// File: tb/tb_ntt_bfu_scheduler.sv
// Directed bench: LOGN=3 instance checked against hand-computed tables, plus a default-size
// instance for the full-length counts and done timing.
module tb_ntt_bfu_scheduler;

  localparam int MAXC = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start3 = 1'b0, mode3 = 1'b0;
  logic start10 = 1'b0, mode10 = 1'b0;
`ifdef NTT_STALL_EN
  logic stall = 1'b0;
`endif

  always #5 clk = ~clk;

  logic       busy3, done3, rd3, bst3, sel3, wr3;
  logic [2:0] ra3, rb3, wa3, wb3;
  logic [3:0] tw3;
  logic [1:0] st3;

  logic        busy10, done10, rd10, bst10, sel10, wr10;
  logic [9:0]  ra10, rb10, wa10, wb10;
  logic [10:0] tw10;
  logic [3:0]  st10;

  ntt_bfu_scheduler #(.LOGN(3), .BFU_LAT(5), .RD_LAT(1)) dut3 (
    .iSYS_CLK(clk), .iSYS_RST(rst_n),
`ifdef NTT_STALL_EN
    .iSTALL(stall),
`endif
    .iSTART(start3), .iMODE(mode3),
    .oBUSY(busy3), .oDONE(done3), .oRD_EN(rd3),
    .oRD_ADDR_A(ra3), .oRD_ADDR_B(rb3), .oTW_ADDR(tw3),
    .oBFU_START(bst3), .oBFU_SEL(sel3), .oWR_EN(wr3),
    .oWR_ADDR_A(wa3), .oWR_ADDR_B(wb3), .oSTAGE(st3)
  );

  ntt_bfu_scheduler dut10 (
    .iSYS_CLK(clk), .iSYS_RST(rst_n),
`ifdef NTT_STALL_EN
    .iSTALL(1'b0),
`endif
    .iSTART(start10), .iMODE(mode10),
    .oBUSY(busy10), .oDONE(done10), .oRD_EN(rd10),
    .oRD_ADDR_A(ra10), .oRD_ADDR_B(rb10), .oTW_ADDR(tw10),
    .oBFU_START(bst10), .oBFU_SEL(sel10), .oWR_EN(wr10),
    .oWR_ADDR_A(wa10), .oWR_ADDR_B(wb10), .oSTAGE(st10)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         off;
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] tw;
  } rd_vec_t;

  rd_vec_t vec [24];

  logic       c_rd [MAXC], c_wr [MAXC], c_done [MAXC], c_busy [MAXC], c_sel [MAXC], c_bst [MAXC];
  logic [2:0] c_ra [MAXC], c_rb [MAXC], c_wa [MAXC], c_wb [MAXC];
  logic [3:0] c_tw [MAXC];
  logic [1:0] c_st [MAXC];
  logic [23:0] c_all [MAXC];

  // Offset k is observed between edge S+k-1 and edge S+k; inputs set at offset k are sampled at S+k.
  task automatic run3(input logic mode, input int pulse_off, input int rst_off, input int stall_off);
    for (int k = 0; k < MAXC; k++) begin
      @(negedge clk);
      start3 = (k == 0) || (k == pulse_off);
      mode3  = (k == 0) ? mode : ~mode;
      rst_n  = !(rst_off >= 0 && k >= rst_off && k < rst_off + 2);
`ifdef NTT_STALL_EN
      stall  = (stall_off >= 0 && k >= stall_off && k < stall_off + 3);
`else
      if (stall_off >= 0) $display("stall requested without NTT_STALL_EN");
`endif
      #1;
      c_rd[k] = rd3;   c_wr[k] = wr3;   c_done[k] = done3;
      c_busy[k] = busy3; c_sel[k] = sel3; c_bst[k] = bst3;
      c_ra[k] = ra3;   c_rb[k] = rb3;   c_wa[k] = wa3;   c_wb[k] = wb3;
      c_tw[k] = tw3;   c_st[k] = st3;
      c_all[k] = {busy3, done3, rd3, ra3, rb3, tw3, bst3, sel3, wr3, wa3, wb3, st3};
    end
    @(negedge clk);
    start3 = 1'b0; mode3 = 1'b0; rst_n = 1'b1;
`ifdef NTT_STALL_EN
    stall = 1'b0;
`endif
  endtask

  task automatic cmp_run(input string tag, input int base, input logic mode_exp, input int done_exp);
    int n_rd, n_wr, n_ovl, n_done, n_busy, n_bst, first_done;
    for (int i = 0; i < 12; i++) begin
      int o;
      o = vec[base + i].off;
      check($sformatf("%s rd_en@%0d", tag, o), 64'(c_rd[o]), 64'd1);
      check($sformatf("%s rd a/b/tw@%0d", tag, o), {52'd0, c_ra[o], c_rb[o], c_tw[o]},
            {52'd0, vec[base + i].a, vec[base + i].b, vec[base + i].tw});
      check($sformatf("%s wr_en@%0d", tag, o + 6), 64'(c_wr[o + 6]), 64'd1);
      check($sformatf("%s wr a/b@%0d", tag, o + 6), {58'd0, c_wa[o + 6], c_wb[o + 6]},
            {58'd0, vec[base + i].a, vec[base + i].b});
    end
    n_rd = 0; n_wr = 0; n_ovl = 0; n_done = 0; n_busy = 0; n_bst = 0; first_done = -1;
    for (int k = 0; k < MAXC; k++) begin
      n_rd  += int'(c_rd[k]);
      n_wr  += int'(c_wr[k]);
      n_ovl += int'(c_rd[k] & c_wr[k]);
      n_done += int'(c_done[k]);
      n_busy += int'(c_busy[k]);
      n_bst  += int'(c_bst[k]);
      if (c_done[k] && first_done < 0) first_done = k;
    end
    check({tag, " read count"}, 64'(n_rd), 64'd12);
    check({tag, " write count"}, 64'(n_wr), 64'd12);
    check({tag, " rd/wr overlap"}, 64'(n_ovl), 64'd0);
    check({tag, " done cycle"}, 64'(first_done), 64'(done_exp));
    check({tag, " done pulses"}, 64'(n_done), 64'd1);
    check({tag, " busy cycles"}, 64'(n_busy), 64'(done_exp - 1));
    check({tag, " bfu_start cycles"}, 64'(n_bst), 64'(done_exp - 1));
    check({tag, " busy first"}, 64'(c_busy[1]), 64'd1);
    check({tag, " busy at done"}, 64'(c_busy[done_exp]), 64'd0);
    check({tag, " bfu_sel"}, 64'(c_sel[5]), 64'(mode_exp));
    check({tag, " stage0"}, 64'(c_st[vec[base].off]), 64'd0);
    check({tag, " stage1"}, 64'(c_st[vec[base + 4].off]), 64'd1);
    check({tag, " stage2"}, 64'(c_st[vec[base + 8].off]), 64'd2);
  endtask

  initial begin
    int n_rd, n_wr, n_done, n_busy, done_off;

    // Forward LOGN=3
    vec[0]  = '{1,  3'd0, 3'd4, 4'd1};  vec[1]  = '{2,  3'd1, 3'd5, 4'd1};
    vec[2]  = '{3,  3'd2, 3'd6, 4'd1};  vec[3]  = '{4,  3'd3, 3'd7, 4'd1};
    vec[4]  = '{11, 3'd0, 3'd2, 4'd2};  vec[5]  = '{12, 3'd1, 3'd3, 4'd2};
    vec[6]  = '{13, 3'd4, 3'd6, 4'd3};  vec[7]  = '{14, 3'd5, 3'd7, 4'd3};
    vec[8]  = '{21, 3'd0, 3'd1, 4'd4};  vec[9]  = '{22, 3'd2, 3'd3, 4'd5};
    vec[10] = '{23, 3'd4, 3'd5, 4'd6};  vec[11] = '{24, 3'd6, 3'd7, 4'd7};
    // Inverse LOGN=3
    vec[12] = '{1,  3'd0, 3'd1, 4'd12}; vec[13] = '{2,  3'd2, 3'd3, 4'd13};
    vec[14] = '{3,  3'd4, 3'd5, 4'd14}; vec[15] = '{4,  3'd6, 3'd7, 4'd15};
    vec[16] = '{11, 3'd0, 3'd2, 4'd10}; vec[17] = '{12, 3'd1, 3'd3, 4'd10};
    vec[18] = '{13, 3'd4, 3'd6, 4'd11}; vec[19] = '{14, 3'd5, 3'd7, 4'd11};
    vec[20] = '{21, 3'd0, 3'd4, 4'd9};  vec[21] = '{22, 3'd1, 3'd5, 4'd9};
    vec[22] = '{23, 3'd2, 3'd6, 4'd9};  vec[23] = '{24, 3'd3, 3'd7, 4'd9};

    repeat (3) @(negedge clk);
    #1;
    check("reset outputs n8", {40'd0, busy3, done3, rd3, ra3, rb3, tw3, bst3, sel3, wr3, wa3, wb3, st3}, 64'd0);
    check("reset outputs n1024", {19'd0, busy10, done10, rd10, ra10, rb10, tw10, bst10, sel10, wr10,
                                  wa10, wb10, st10}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run3(1'b0, -1, -1, -1);
    cmp_run("fwd", 0, 1'b0, 31);

    run3(1'b1, -1, -1, -1);
    cmp_run("inv", 12, 1'b1, 31);

    // A start pulse mid-run, with iMODE toggled, must not disturb the run.
    run3(1'b0, 5, -1, -1);
    cmp_run("fwd+start", 0, 1'b0, 31);

    // Mid-run reset during an inverse run: all outputs clear, nothing further is written.
    run3(1'b1, -1, 15, -1);
    check("rst pre-reset read", {57'd0, c_rd[11], c_ra[11], c_rb[11]}, {57'd0, 1'b1, 3'd0, 3'd2});
    check("rst outputs cleared", 64'(c_all[16]), 64'd0);
    n_rd = 0; n_wr = 0; n_done = 0;
    for (int k = 16; k < MAXC; k++) begin
      n_rd += int'(c_rd[k]); n_wr += int'(c_wr[k]); n_done += int'(c_done[k]);
    end
    check("rst no reads after", 64'(n_rd), 64'd0);
    check("rst no writes after", 64'(n_wr), 64'd0);
    check("rst no done", 64'(n_done), 64'd0);

    run3(1'b0, -1, -1, -1);
    cmp_run("restart", 0, 1'b0, 31);

`ifdef NTT_STALL_EN
    run3(1'b0, -1, -1, 2);
    check("stall rd@1", {57'd0, c_rd[1], c_ra[1], c_rb[1]}, {57'd0, 1'b1, 3'd0, 3'd4});
    check("stall no rd 2..4", {61'd0, c_rd[2], c_rd[3], c_rd[4]}, 64'd0);
    check("stall rd@5", {53'd0, c_rd[5], c_ra[5], c_rb[5], c_tw[5]}, {53'd0, 1'b1, 3'd1, 3'd5, 4'd1});
    check("stall wr@7", {57'd0, c_wr[7], c_wa[7], c_wb[7]}, {57'd0, 1'b1, 3'd0, 3'd4});
    check("stall no wr 8..10", {61'd0, c_wr[8], c_wr[9], c_wr[10]}, 64'd0);
    check("stall wr@11", {57'd0, c_wr[11], c_wa[11], c_wb[11]}, {57'd0, 1'b1, 3'd1, 3'd5});
    check("stall stage1 rd@14", {57'd0, c_rd[14], c_ra[14], c_rb[14]}, {57'd0, 1'b1, 3'd0, 3'd2});
    check("stall done@34", {62'd0, c_done[33], c_done[34]}, 64'd1);
`endif

    // Default size, forward.
    n_rd = 0; n_wr = 0; n_busy = 0; done_off = -1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      start10 = (k == 0);
      #1;
      n_rd   += int'(rd10);
      n_wr   += int'(wr10);
      n_busy += int'(busy10);
      if (k == 1) check("n1024 first read", {1'd0, rd10, ra10, rb10, tw10}, {1'd0, 1'b1, 10'd0, 10'd512, 11'd1});
      if (done10) begin
        done_off = k;
        break;
      end
    end
    start10 = 1'b0;
    check("n1024 done cycle", 64'(done_off), 64'd5181);
    check("n1024 read count", 64'(n_rd), 64'd5120);
    check("n1024 write count", 64'(n_wr), 64'd5120);
    check("n1024 busy cycles", 64'(n_busy), 64'd5180);
    @(negedge clk);
    #1;
    check("n1024 idle after done", {62'd0, busy10, done10}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ntt_bfu_scheduler.md
# ntt_bfu_scheduler

Sequences the 5-stage pipelined butterfly unit (MDL_pipe_BUF) through a full in-place NTT or inverse NTT on one polynomial bank. It issues one butterfly per cycle: coefficient-RAM read addresses, twiddle-ROM address and the butterfly mode select. It carries each butterfly's destination addresses through a delay line matched to RAM plus butterfly latency, so write-back lines up with the unit's oA/oB. It sits between the top-level command FSM and the coefficient RAM / twiddle ROM / butterfly datapath.

## Interface
- LOGN, 10, log2 of polynomial length N; N/2 butterflies per stage, LOGN stages
- BFU_LAT, 5, butterfly pipeline latency in cycles (iA/iB/iW sampled to oA/oB valid)
- RD_LAT, 1, coefficient RAM and twiddle ROM read latency in cycles
- iSYS_CLK  in  1  system clock, all logic on rising edge
- iSYS_RST  in  1  reset; synchronous, active-low
- iSTART  in  1  start pulse, sampled only in IDLE
- iMODE  in  1  0 = forward CT NTT, 1 = inverse GS NTT; latched at start
- oBUSY  out  1  high from the cycle after start acceptance until oDONE
- oDONE  out  1  one-cycle pulse after the final write-back
- oRD_EN  out  1  coefficient read strobe
- oRD_ADDR_A, oRD_ADDR_B  out  LOGN  butterfly operand addresses
- oTW_ADDR  out  LOGN+1  twiddle ROM address, issued with oRD_EN
- oBFU_START  out  1  butterfly enable; high while oBUSY
- oBFU_SEL  out  1  butterfly mode; equals latched iMODE (1 = GS)
- oWR_EN  out  1  write strobe, aligned with valid oA/oB
- oWR_ADDR_A, oWR_ADDR_B  out  LOGN  write-back addresses for oA/oB
- oSTAGE  out  $clog2(LOGN)  current issue stage

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE when iSTART=1. Stage s=0, butterfly index j=0, mode latched.
- ISSUE, one butterfly per cycle:
  - Outputs: oRD_EN=1 and addresses from (s, j). j increments each cycle.
  - At j=N/2-1 the state moves to DRAIN.
- Forward addressing: len=N>>(s+1), grp=j>>log2(len), off=j&(len-1).
  - A=grp·2·len+off, B=A+len, oTW_ADDR=(1<<s)+grp.
- Inverse addressing: len=1<<s, same A/B formulas, oTW_ADDR=N+(N>>(s+1))+grp.
- Delay line, depth RD_LAT+BFU_LAT: each entry holds {valid, A, B}. It shifts every cycle; its head drives oWR_EN/oWR_ADDR_A/oWR_ADDR_B.
- DRAIN: no reads while the line holds valid entries. The cycle after the last write of stage s, the next step is:
  - s<LOGN-1: ISSUE with s+1 and j=0, so a stage never reads data the previous stage is still writing.
  - s=LOGN-1: DONE.
- DONE: oDONE=1 for one cycle → IDLE; oBUSY falls in the same cycle.
- iSTART while not IDLE is ignored. iMODE changes mid-run are ignored.
- Reset, including mid-run: state=IDLE, counters and delay line cleared. All outputs 0, including oBUSY, oDONE, oRD_EN, oWR_EN, oBFU_START, oBFU_SEL, all addresses and oSTAGE. In-flight butterflies are discarded with no writes.

## Timing
- iSTART sampled at cycle S. First oRD_EN at S+1.
- Stage period is N/2 issue cycles plus RD_LAT+BFU_LAT drain cycles (518 for defaults).
- Each write occurs RD_LAT+BFU_LAT cycles after its read.
- oDONE at S + LOGN·(N/2+RD_LAT+BFU_LAT) + 1, i.e. S+5181 for defaults.
- Read and write never target the same stage's pending data. A read and an unrelated write in the same cycle are legal only across the stage boundary, and the boundary rule above forbids it.

## Configuration
- NTT_STALL_EN defined: adds input port iSTALL (1 bit).
  - While iSTALL=1 in ISSUE: oRD_EN=0, j and s hold, and a bubble (valid=0) enters the delay line.
  - In-flight entries keep draining, because the butterfly cannot stall. Issue resumes the cycle iSTALL falls.
  - oDONE shifts later by the number of stalled ISSUE cycles.
- NTT_STALL_EN not defined: no iSTALL port; issue is never interrupted.

## Test plan
- LOGN=3, forward, iSTART at S → reads at S+1..S+4 are (0,4),(1,5),(2,6),(3,7) with tw 1. Stage 1 is (0,2),(1,3),(4,6),(5,7) with tw 2,2,3,3, starting S+11. Stage 2 is (0,1),(2,3),(4,5),(6,7) with tw 4,5,6,7, starting S+21. oDONE at S+31.
- LOGN=3, inverse → oBFU_SEL=1. Stage-0 tw 12,13,14,15 on pairs (0,1)…(6,7). Stage 1 tw 10,10,11,11. Stage 2 tw 9 on (0,4)…(3,7).
- Write alignment: every oWR_EN occurs 6 cycles after its oRD_EN with identical addresses. No oRD_EN occurs while any oWR_EN of the same stage is pending.
- Defaults, forward → exactly 5120 oRD_EN and 5120 oWR_EN cycles. oDONE at S+5181. oBUSY is high S+1..S+5180.
- iSYS_RST=0 at S+15 during the LOGN=3 run → next cycle all outputs 0 and no further oWR_EN. A new iSTART after release restarts from stage 0.
- iSTART pulsed at S+5 while busy → ignored, oDONE still at S+31. With NTT_STALL_EN, iSTALL high for 3 ISSUE cycles → oDONE at S+34.
